// File: rtl/ifft1024_pkg.sv
// Shared types, widths and helpers for the streaming IFFT core.
package ifft1024_pkg;

    localparam int SW     = 16;   // external sample width
    localparam int IW     = 32;   // internal RAM word width
    localparam int TW     = 17;   // twiddle width, Q1.15 with room for +1.0
    localparam int QS     = 15;   // twiddle fraction bits
    localparam int MAX_AW = 10;   // widest supported address (N = 1024)

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_UNLOAD  = 2'd2
    } state_t;

    // Reverse the low aw bits of x; bits above aw come back zero.
    function automatic logic [MAX_AW-1:0] bitrev(input logic [MAX_AW-1:0] x, input int aw);
        logic [MAX_AW-1:0] y;
        y = {<<{x}};
        return y >> (MAX_AW - aw);
    endfunction

    // Clamp a 32-bit internal value to the signed 16-bit output range.
    function automatic logic signed [SW-1:0] sat16(input logic signed [IW-1:0] x);
        localparam logic signed [IW-1:0] SMAX = 32767;
        localparam logic signed [IW-1:0] SMIN = -32768;
        if (x > SMAX) return 16'sh7fff;
        if (x < SMIN) return 16'sh8000;
        return SW'(x);
    endfunction

endpackage

// File: rtl/ifft1024_if.sv
// Streaming sample interface: frequency bins in, time samples out.
interface ifft1024_if;
    import ifft1024_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic signed [SW-1:0] in_re;
    logic signed [SW-1:0] in_im;
    logic signed [SW-1:0] out_re;
    logic signed [SW-1:0] out_im;
    logic                 done;
    logic                 out_last;
    logic                 busy;

    modport master (output in_valid, in_re, in_im,
                    input  in_ready, out_re, out_im, done, out_last, busy);
    modport slave  (input  in_valid, in_re, in_im,
                    output in_ready, out_re, out_im, done, out_last, busy);
endinterface

// File: rtl/ifft1024_twiddle_rom.sv
// Synchronous twiddle ROM, W^m = cos(2*pi*m/N) - j*sin(2*pi*m/N), Q1.15 in 17 bits.
module ifft1024_twiddle_rom
    import ifft1024_pkg::*;
#(
    parameter int N  = 1024,
    parameter int AW = 10
) (
    input  logic                 clk,
    input  logic [AW-2:0]        addr,
    output logic signed [TW-1:0] wre,
    output logic signed [TW-1:0] wim
);
    localparam real TWO_PI = 6.283185307179586;

    logic signed [TW-1:0] tab_re [N/2];
    logic signed [TW-1:0] tab_im [N/2];

    // Constant table, rounded to nearest; folds to ROM contents at elaboration.
    for (genvar m = 0; m < N/2; m++) begin : g_tab
        assign tab_re[m] = TW'($rtoi($floor( 32768.0 * $cos(TWO_PI * m / N) + 0.5)));
        assign tab_im[m] = TW'($rtoi($floor(-32768.0 * $sin(TWO_PI * m / N) + 0.5)));
    end

    // One-cycle registered read.
    always_ff @(posedge clk) begin
        wre <= tab_re[addr];
        wim <= tab_im[addr];
    end
endmodule

// File: rtl/ifft1024.sv
// Streaming radix-2 DIT inverse FFT via the conjugate trick, computed in place.
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   ST_LOAD    | accept N bins, store conj(X[k]) at bit-reversed address
//   ST_COMPUTE | forward butterflies, 3 cycles each, >>>1 per stage
//   ST_UNLOAD  | read n = 0..N-1, output conj(result), then drain 2 cycles
module ifft1024
    import ifft1024_pkg::*;
#(
    parameter int N     = 1024,
    parameter int LOG2N = 10,
    parameter int AW    = 10
) (
    input  logic       clk,
    input  logic       rst,
    ifft1024_if.slave  bus
);
    localparam int PW = 50;

    state_t state, state_nxt;

    logic [AW-1:0]      i_cnt;
    logic [AW:0]        k, k_nxt, kb, diff, n_cnt;
    logic [AW-1:0]      j, r, jr;
    logic [3:0]         l;
    logic [1:0]         ph;
    logic               accept, j_wrap, stage_end, last_stage, bf_wr;
    logic [MAX_AW-1:0]  br_full;

    logic [AW-1:0]        addr_a, addr_b;
    logic                 we_a, we_b;
    logic signed [IW-1:0] wa_re, wa_im, wb_re, wb_im;
    logic signed [IW-1:0] qa_re, qa_im, qb_re, qb_im;
    logic signed [IW-1:0] mem_re [N];
    logic signed [IW-1:0] mem_im [N];
    logic signed [TW-1:0] w_re, w_im;

    logic signed [PW-1:0] ar, ai, br, bi, wr, wi, p_re, p_im, t_re, t_im;
    logic signed [PW-1:0] sa_re, sa_im, sb_re, sb_im;

    logic                 rd_v, rd_last, done_q, last_q;
    logic signed [SW-1:0] out_re_q, out_im_q;
    logic                 unused_bits;

    assign accept     = bus.in_valid && (state == ST_LOAD);
    assign j_wrap     = ({1'b0, j} == diff - (AW+1)'(1));
    assign k_nxt      = j_wrap ? k + diff + (AW+1)'(1) : k + (AW+1)'(1);
    assign kb         = k + diff;
    assign stage_end  = (k_nxt >= (AW+1)'(N));
    assign last_stage = (l == 4'(LOG2N-1));
    assign bf_wr      = (state == ST_COMPUTE) && (ph == 2'd0);
    assign jr         = j * r;
    assign br_full    = bitrev(MAX_AW'(i_cnt), AW);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= ST_LOAD;
        else      state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD:    if (accept && i_cnt == AW'(N-1)) state_nxt = ST_COMPUTE;
            ST_COMPUTE: if (bf_wr && stage_end && last_stage) state_nxt = ST_UNLOAD;
            ST_UNLOAD:  if (n_cnt == (AW+1)'(N+1)) state_nxt = ST_LOAD;
            default:    state_nxt = ST_LOAD;
        endcase
    end

    // Load index, butterfly index walk (ph is a 2..0 down-counter per butterfly) and unload address.
    always_ff @(posedge clk) begin
        if (!rst) begin
            i_cnt <= '0; k <= '0; j <= '0; l <= '0; ph <= 2'd2; n_cnt <= '0;
            diff  <= (AW+1)'(1);
            r     <= AW'(N/2);
        end else begin
            case (state)
                ST_LOAD: begin
                    if (accept) i_cnt <= i_cnt + AW'(1);
                    k <= '0; j <= '0; l <= '0; ph <= 2'd2; n_cnt <= '0;
                    diff <= (AW+1)'(1);
                    r    <= AW'(N/2);
                end
                ST_COMPUTE: begin
                    ph <= (ph == 2'd0) ? 2'd2 : ph - 2'd1;
                    if (bf_wr) begin
                        if (stage_end) begin
                            k <= '0; j <= '0; l <= l + 4'd1;
                            diff <= diff << 1;
                            r    <= r >> 1;
                        end else begin
                            k <= k_nxt;
                            j <= j_wrap ? '0 : j + AW'(1);
                        end
                    end
                end
                ST_UNLOAD: begin
                    n_cnt <= n_cnt + (AW+1)'(1);
                    i_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    // Butterfly: t = (W*b)>>>15 at full width, A' = (a+t)>>>1, B' = (a-t)>>>1.
    always_comb begin
        ar    = PW'(qa_re);
        ai    = PW'(qa_im);
        br    = PW'(qb_re);
        bi    = PW'(qb_im);
        wr    = PW'(w_re);
        wi    = PW'(w_im);
        p_re  = wr * br - wi * bi;
        p_im  = wi * br + wr * bi;
        t_re  = p_re >>> QS;
        t_im  = p_im >>> QS;
        sa_re = ar + t_re;
        sa_im = ai + t_im;
        sb_re = ar - t_re;
        sb_im = ai - t_im;
    end

    // RAM port steering: conjugated input on load, butterfly results on compute, reads on unload.
    always_comb begin
        addr_a = k[AW-1:0];
        addr_b = kb[AW-1:0];
        we_a   = 1'b0;
        we_b   = 1'b0;
        wa_re  = sa_re[IW:1];
        wa_im  = sa_im[IW:1];
        wb_re  = sb_re[IW:1];
        wb_im  = sb_im[IW:1];
        case (state)
            ST_LOAD: begin
                addr_a = br_full[AW-1:0];
                we_a   = accept;
                wa_re  = IW'(bus.in_re);
                wa_im  = -IW'(bus.in_im);
            end
            ST_COMPUTE: begin
                we_a = bf_wr;
                we_b = bf_wr;
            end
            ST_UNLOAD: addr_a = n_cnt[AW-1:0];
            default: ;
        endcase
    end

    // Dual-port data RAM (re and im planes), 1-cycle read latency, read-before-write.
    always_ff @(posedge clk) begin
        if (we_a) begin
            mem_re[addr_a] <= wa_re;
            mem_im[addr_a] <= wa_im;
        end
        if (we_b) begin
            mem_re[addr_b] <= wb_re;
            mem_im[addr_b] <= wb_im;
        end
        qa_re <= mem_re[addr_a];
        qa_im <= mem_im[addr_a];
        qb_re <= mem_re[addr_b];
        qb_im <= mem_im[addr_b];
    end

    ifft1024_twiddle_rom #(.N(N), .AW(AW)) u_rom (
        .clk  (clk),
        .addr (jr[AW-2:0]),
        .wre  (w_re),
        .wim  (w_im)
    );

    // Output pipeline: RAM read valid, then conjugate, saturate and register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_v <= 1'b0; rd_last <= 1'b0; done_q <= 1'b0; last_q <= 1'b0;
            out_re_q <= '0; out_im_q <= '0;
        end else begin
            rd_v     <= (state == ST_UNLOAD) && (n_cnt <  (AW+1)'(N));
            rd_last  <= (state == ST_UNLOAD) && (n_cnt == (AW+1)'(N-1));
            done_q   <= rd_v;
            last_q   <= rd_last;
            out_re_q <= rd_v ? sat16(qa_re)  : '0;
            out_im_q <= rd_v ? sat16(-qa_im) : '0;
        end
    end

    assign bus.in_ready = (state == ST_LOAD);
    assign bus.busy     = (state != ST_LOAD);
    assign bus.done     = done_q;
    assign bus.out_last = last_q;
    assign bus.out_re   = out_re_q;
    assign bus.out_im   = out_im_q;

    // Sink for deliberately discarded guard bits, rounding LSBs and address carries.
    assign unused_bits = ^{sa_re, sa_im, sb_re, sb_im, kb, jr, br_full};
endmodule
